// File: rtl/present_pkg.sv
// Shared PRESENT constants and the 4-bit S-box used by the key schedule.
package present_pkg;

    localparam int KEY_W   = 80;
    localparam int STATE_W = 64;
    localparam int RK_LO   = 16;

    // Nibble i of this constant is S(i)
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/key_update.sv
// One PRESENT-80 key-register update step: rotate, S-box top nibble,
// mix round counter into bits 19..15.
module key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] k,
    input  logic [4:0]       i,
    output logic [KEY_W-1:0] k_next
);

    logic [KEY_W-1:0] t;

    assign t = {k[18:0], k[79:19]};

    assign k_next = {sbox(t[79:76]), t[75:20], t[19:15] ^ i, t[14:0]};

endmodule

// File: rtl/key_schedule.sv
// Iterative PRESENT-80 key schedule streaming one key-register state
// per accepted transfer over a valid/ready interface.
module key_schedule
    import present_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] k_in,
    output logic             busy,
    output logic             k_valid,
    input  logic             k_ready,
    output logic [KEY_W-1:0] k_out,
    output logic [4:0]       k_idx,
    output logic             done
);

    ks_state_t        state;
    ks_state_t        state_next;
    logic [5:0]       cnt;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] key_next;
    logic             done_q;
    logic             last;
    logic             load;
    logic             advance;

    assign last    = (cnt == 6'(ROUNDS));
    assign load    = (state == IDLE) && start;
    assign advance = (state == EMIT) && k_ready;

    key_update u_update (
        .k      (key_reg),
        .i      (cnt[4:0]),
        .k_next (key_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = EMIT;
            EMIT: if (k_ready && last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Final transfer leaves key_reg/cnt untouched so outputs hold in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= advance && last;
            if (load) begin
                key_reg <= k_in;
                cnt     <= 6'd1;
            end else if (advance && !last) begin
                key_reg <= key_next;
                cnt     <= cnt + 6'd1;
            end
        end
    end

    always_comb begin
        busy    = (state == EMIT);
        k_valid = (state == EMIT);
        k_out   = key_reg;
        k_idx   = cnt[4:0];
        done    = done_q;
    end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: reset, known vectors, back-pressure,
// ignored start, start in done cycle, and full-cipher end-to-end check.
module tb_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [79:0] k_in;
    logic        busy;
    logic        k_valid;
    logic        k_ready;
    logic [79:0] k_out;
    logic [4:0]  k_idx;
    logic        done;

    int checks;
    int failures;

    logic [79:0] keys [0:32];
    logic [3:0]  sb   [0:15];

    key_schedule #(.ROUNDS(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_in    (k_in),
        .busy    (busy),
        .k_valid (k_valid),
        .k_ready (k_ready),
        .k_out   (k_out),
        .k_idx   (k_idx),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference PRESENT-80 encryption of x=0 using captured round keys
    function automatic logic [63:0] encrypt_zero();
        logic [63:0] x;
        logic [63:0] y;
        x = '0;
        for (int r = 1; r <= 31; r++) begin
            x = x ^ keys[r][79:16];
            for (int n = 0; n < 16; n++) x[n*4 +: 4] = sb[x[n*4 +: 4]];
            y = '0;
            for (int b = 0; b < 63; b++) y[(b * 16) % 63] = x[b];
            y[63] = x[63];
            x = y;
        end
        return x ^ keys[32][79:16];
    endfunction

    initial begin
        logic [63:0] ct;
        checks   = 0;
        failures = 0;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        rst     = 1'b0;
        start   = 1'b0;
        k_in    = '0;
        k_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_valid", 80'(k_valid), 80'd0);
        chk("rst_done", 80'(done), 80'd0);
        chk("rst_kout", k_out, 80'd0);
        chk("rst_kidx", 80'(k_idx), 80'd0);

        rst = 1'b1;
        @(negedge clk);
        k_in    = '0;
        start   = 1'b1;
        k_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int r = 1; r <= 32; r++) begin
            chk("run_valid", 80'(k_valid), 80'd1);
            chk("run_busy", 80'(busy), 80'd1);
            chk("run_done", 80'(done), 80'd0);
            chk("run_idx", 80'(k_idx), 80'(r % 32));
            keys[r] = k_out;
            if (r == 1) chk("zero_idx1", k_out, 80'h0);
            if (r == 2) chk("zero_idx2", k_out, 80'hC0000000000000008000);
            if (r == 5) begin
                start = 1'b1;
                k_in  = 80'h123456789ABCDEF01234;
            end
            if (r == 6) start = 1'b0;
            if (r == 7) begin
                k_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_idx", 80'(k_idx), 80'd7);
                    chk("stall_kout", k_out, keys[7]);
                    chk("stall_valid", 80'(k_valid), 80'd1);
                end
                k_ready = 1'b1;
            end
            @(negedge clk);
        end

        chk("done_pulse", 80'(done), 80'd1);
        chk("done_valid", 80'(k_valid), 80'd0);
        chk("done_busy", 80'(busy), 80'd0);
        chk("idle_idx", 80'(k_idx), 80'd0);
        chk("idle_kout", k_out, keys[32]);
        ct = encrypt_zero();
        chk("cipher", 80'(ct), 80'h5579C1387B228445);

        start = 1'b1;
        k_in  = 80'hFFFFFFFFFFFFFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        chk("done_once", 80'(done), 80'd0);
        chk("ones_valid", 80'(k_valid), 80'd1);
        chk("ones_idx1", 80'(k_idx), 80'd1);
        chk("ones_k1", k_out, 80'hFFFFFFFFFFFFFFFFFFFF);
        @(negedge clk);
        chk("ones_idx2", 80'(k_idx), 80'd2);
        chk("ones_k2", k_out, 80'h2FFFFFFFFFFFFFFF7FFF);
        @(negedge clk);
        chk("ones_idx3", 80'(k_idx), 80'd3);

        rst = 1'b0;
        #1;
        chk("mid_busy", 80'(busy), 80'd0);
        chk("mid_valid", 80'(k_valid), 80'd0);
        chk("mid_done", 80'(done), 80'd0);
        chk("mid_kout", k_out, 80'd0);
        chk("mid_kidx", 80'(k_idx), 80'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_valid", 80'(k_valid), 80'd0);
        chk("post_done", 80'(done), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
